// File: rtl/fixed_latency_divider.sv
// Fixed-latency signed divider: 2W-bit dividend / W-bit divisor, restoring, one quotient bit per clock.
// Optional simulation-only result checker enabled by defining DIV_SELFCHK_EN.
module fixed_latency_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [2*WIDTH-1:0] dvdnd,
   input  logic [WIDTH-1:0]   dvsor,
   input  logic               start,
   output logic [WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]   rmdr,
   output logic               valid,
   output logic               ovfl,
   output logic               dz
);

   localparam int LATENCY = WIDTH + 2;
   localparam int CW      = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               start_q, start_d;
   logic               arm_q, arm_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   dsm_q, dsm_d;
   logic [WIDTH-1:0]   dlo_q, dlo_d;
   logic               sd_q, sd_d;
   logic               qneg_q, qneg_d;
   logic               dzf_q, dzf_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   fq_q, fq_d;
   logic [WIDTH-1:0]   fr_q, fr_d;
   logic               fo_q, fo_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rmdr_q, rmdr_d;
   logic               valid_q, valid_d;
   logic               ovfl_q, ovfl_d;
   logic               dz_q, dz_d;

   logic               launch;
   logic [2*WIDTH-1:0] mag_dvdnd;
   logic [WIDTH-1:0]   mag_dvsor;
   logic [WIDTH:0]     trial;
   logic               ge;
   logic               neg;

   assign quot  = quot_q;
   assign rmdr  = rmdr_q;
   assign valid = valid_q;
   assign ovfl  = ovfl_q;
   assign dz    = dz_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      acc_d     = acc_q;
      dsm_d     = dsm_q;
      dlo_d     = dlo_q;
      sd_d      = sd_q;
      qneg_d    = qneg_q;
      dzf_d     = dzf_q;
      ovf_d     = ovf_q;
      fq_d      = fq_q;
      fr_d      = fr_q;
      fo_d      = fo_q;
      quot_d    = quot_q;
      rmdr_d    = rmdr_q;
      ovfl_d    = ovfl_q;
      dz_d      = dz_q;
      start_d   = start;
      // arm blocks a launch from a start level that was already high across reset release
      arm_d     = arm_q | ~start;
      mag_dvdnd = dvdnd[2*WIDTH-1] ? -dvdnd : dvdnd;
      mag_dvsor = dvsor[WIDTH-1] ? -dvsor : dvsor;
      trial     = {rem_q, acc_q[WIDTH-1]};
      ge        = trial >= {1'b0, dsm_q};
      neg       = qneg_q && (acc_q != '0);
      launch    = (state_q == IDLE) && start && !start_q && arm_q;
      valid_d   = (state_q == DONE) && (!valid_q || start);

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               // High half of the dividend seeds the partial remainder; low half shifts in bit by bit
               rem_d   = mag_dvdnd[2*WIDTH-1:WIDTH];
               acc_d   = mag_dvdnd[WIDTH-1:0];
               dsm_d   = mag_dvsor;
               dlo_d   = dvdnd[WIDTH-1:0];
               sd_d    = dvdnd[2*WIDTH-1];
               qneg_d  = dvdnd[2*WIDTH-1] ^ dvsor[WIDTH-1];
               dzf_d   = (dvsor == '0);
               ovf_d   = (mag_dvdnd[2*WIDTH-1:WIDTH] >= mag_dvsor);
               cnt_d   = CW'(LATENCY - 3);
               state_d = ITER;
            end
         end
         ITER: begin
            rem_d = ge ? WIDTH'(trial - {1'b0, dsm_q}) : trial[WIDTH-1:0];
            acc_d = {acc_q[WIDTH-2:0], ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            if (dzf_q) begin
               fq_d = '1;
               fr_d = dlo_q;
               fo_d = 1'b0;
            end else if (ovf_q || (!neg && acc_q[WIDTH-1]) ||
                         (neg && acc_q[WIDTH-1] && (acc_q[WIDTH-2:0] != '0))) begin
               fq_d = {1'b1, {(WIDTH-1){1'b0}}};
               fr_d = '0;
               fo_d = 1'b1;
            end else begin
               fq_d = neg ? -acc_q : acc_q;
               fr_d = sd_q ? -rem_q : rem_q;
               fo_d = 1'b0;
            end
            state_d = DONE;
         end
         DONE: begin
            if (!valid_q) begin
               quot_d = fq_q;
               rmdr_d = fr_q;
               ovfl_d = fo_q;
               dz_d   = dzf_q;
            end
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         start_q <= 1'b0;
         arm_q   <= 1'b0;
         rem_q   <= '0;
         acc_q   <= '0;
         dsm_q   <= '0;
         dlo_q   <= '0;
         sd_q    <= 1'b0;
         qneg_q  <= 1'b0;
         dzf_q   <= 1'b0;
         ovf_q   <= 1'b0;
         fq_q    <= '0;
         fr_q    <= '0;
         fo_q    <= 1'b0;
         quot_q  <= '0;
         rmdr_q  <= '0;
         valid_q <= 1'b0;
         ovfl_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         arm_q   <= arm_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         dsm_q   <= dsm_d;
         dlo_q   <= dlo_d;
         sd_q    <= sd_d;
         qneg_q  <= qneg_d;
         dzf_q   <= dzf_d;
         ovf_q   <= ovf_d;
         fq_q    <= fq_d;
         fr_q    <= fr_d;
         fo_q    <= fo_d;
         quot_q  <= quot_d;
         rmdr_q  <= rmdr_d;
         valid_q <= valid_d;
         ovfl_q  <= ovfl_d;
         dz_q    <= dz_d;
      end
   end

`ifdef DIV_SELFCHK_EN
   integer             err_cnt = 0;
   logic [2*WIDTH-1:0] chk_a = '0;
   logic [WIDTH-1:0]   chk_b = '0;
   logic               chk_v = 1'b0;

   always @(posedge clock) begin
      if (launch) begin
         chk_a <= dvdnd;
         chk_b <= dvsor;
      end
   end

   always @(negedge clock) begin
      logic signed [2*WIDTH-1:0] eq, er;
      if (valid && !chk_v && !dz && !ovfl) begin
         eq = $signed(chk_a) / $signed({{WIDTH{chk_b[WIDTH-1]}}, chk_b});
         er = $signed(chk_a) % $signed({{WIDTH{chk_b[WIDTH-1]}}, chk_b});
         if ((eq[WIDTH-1:0] !== quot) || (er[WIDTH-1:0] !== rmdr)) begin
            err_cnt = err_cnt + 1;
            $display("DIV MISMATCH dvdnd=%0h dvsor=%0h quot=%0h rmdr=%0h exp_quot=%0h exp_rmdr=%0h",
                     chk_a, chk_b, quot, rmdr, eq[WIDTH-1:0], er[WIDTH-1:0]);
         end
      end
      chk_v = valid;
   end
`endif

endmodule

// File: tb/tb_fixed_latency_divider.sv
// Self-checking bench for fixed_latency_divider: directed and random divisions against an arithmetic model.
module tb_fixed_latency_divider;

   localparam int WIDTH = 32;
   localparam int EXP_LAT = WIDTH + 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] dvdnd;
   logic [31:0] dvsor;
   logic        start;
   logic [31:0] quot;
   logic [31:0] rmdr;
   logic        valid;
   logic        ovfl;
   logic        dz;

   int checks = 0;
   int errors = 0;
   int lat;
   bit got;

   always #5 clock = ~clock;

   fixed_latency_divider #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .dvdnd (dvdnd),
      .dvsor (dvsor),
      .start (start),
      .quot  (quot),
      .rmdr  (rmdr),
      .valid (valid),
      .ovfl  (ovfl),
      .dz    (dz)
   );

   // Reference: exact signed division in a wider type, then the range/zero rules
   task automatic model(input logic [63:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic o, output logic z);
      logic signed [65:0] sa, sb, sq, sr;
      sa = {{2{a[63]}}, a};
      sb = {{34{b[31]}}, b};
      if (b == 32'd0) begin
         z = 1'b1; o = 1'b0; q = 32'hFFFF_FFFF; r = a[31:0];
      end else begin
         sq = sa / sb;
         sr = sa % sb;
         z  = 1'b0;
         if (sq > 66'sd2147483647 || sq < -66'sd2147483648) begin
            o = 1'b1; q = 32'h8000_0000; r = 32'd0;
         end else begin
            o = 1'b0; q = sq[31:0]; r = sr[31:0];
         end
      end
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // hold: drop start after that many clocks (0 keeps it high); repulse toggles start during ITER
   task automatic apply_stimulus(input logic [63:0] a, input logic [31:0] b,
                                 input int hold, input bit repulse);
      @(negedge clock);
      dvdnd = a;
      dvsor = b;
      start = 1'b1;
      @(posedge clock);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 60) begin
         @(posedge clock);
         #1;
         lat++;
         if (valid) got = 1'b1;
         if (lat == hold) start = 1'b0;
         if (repulse && lat == 7) start = 1'b1;
         if (repulse && lat == 20) start = 1'b0;
      end
   endtask

   task automatic check_result(input string tag, input logic [63:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      logic eo, ez;
      model(a, b, eq, er, eo, ez);
      check_output({tag, "/latency"}, 64'(lat), 64'(EXP_LAT));
      check_output({tag, "/quot"}, 64'(quot), 64'(eq));
      check_output({tag, "/rmdr"}, 64'(rmdr), 64'(er));
      check_output({tag, "/ovfl"}, 64'(ovfl), 64'(eo));
      check_output({tag, "/dz"}, 64'(dz), 64'(ez));
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                         input int hold, input bit repulse);
      apply_stimulus(a, b, hold, repulse);
      check_result(tag, a, b);
      @(posedge clock);
      #1;
      check_output({tag, "/valid_one_cycle"}, 64'(valid), 64'd0);
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(posedge clock);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [39:0] rx;
      bit seen;

      reset = 1'b0;
      start = 1'b0;
      dvdnd = '0;
      dvsor = '0;
      #12;
      check_output("reset/quot", 64'(quot), 64'd0);
      check_output("reset/rmdr", 64'(rmdr), 64'd0);
      check_output("reset/valid", 64'(valid), 64'd0);
      check_output("reset/ovfl", 64'(ovfl), 64'd0);
      check_output("reset/dz", 64'(dz), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);

      $display("[TB] 100/7 with start held through completion");
      apply_stimulus(64'd100, 32'd7, 0, 1'b0);
      check_result("t1", 64'd100, 32'd7);
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      check_output("t1/valid_held", 64'(valid), 64'd1);
      start = 1'b0;
      @(posedge clock);
      #1;
      check_output("t1/valid_drop", 64'(valid), 64'd0);
      repeat (2) @(posedge clock);

      $display("[TB] sign combinations");
      run_op("t2a", -64'sd100, 32'd7, 3, 1'b0);
      run_op("t2b", -64'sd100, -32'sd7, 3, 1'b0);
      run_op("t2c", 64'd100, -32'sd7, 3, 1'b0);

      $display("[TB] overflow boundaries");
      run_op("t4a", 64'h1_0000_0000, 32'd1, 3, 1'b0);
      run_op("t4b", 64'hFFFF_FFFF_8000_0000, 32'd1, 3, 1'b0);
      run_op("t4c", 64'h0000_0000_8000_0000, 32'd1, 3, 1'b0);
      run_op("t4d", 64'hFFFF_FFFF_8000_0001, 32'hFFFF_FFFF, 3, 1'b0);

      $display("[TB] divide by zero");
      run_op("t3", 64'd5, 32'd0, 3, 1'b0);

      $display("[TB] reset mid-operation");
      @(negedge clock);
      dvdnd = 64'd100;
      dvsor = 32'd7;
      start = 1'b1;
      @(posedge clock);
      repeat (10) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check_output("t5/valid", 64'(valid), 64'd0);
      check_output("t5/quot", 64'(quot), 64'd0);
      check_output("t5/rmdr", 64'(rmdr), 64'd0);
      check_output("t5/dz", 64'(dz), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (valid) seen = 1'b1;
      end
      check_output("t5/no_launch_held_start", 64'(seen), 64'd0);
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(posedge clock);
      run_op("t5/fresh", 64'd100, 32'd7, 3, 1'b0);

      $display("[TB] random exact products");
      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (rb == 32'd0) rb = 32'd1;
         run_op("t6", {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb}, rb, 33, (i == 0));
         if (!ovfl) check_output("t6/quot_is_a", 64'(quot), 64'(ra));
      end

      $display("[TB] random general dividends");
      for (int i = 0; i < 4; i++) begin
         rx = {$urandom, $urandom} >> 24;
         rb = $urandom;
         if (rb == 32'd0) rb = 32'd3;
         run_op("t7", {{24{rx[39]}}, rx}, rb, 3, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
